// File: rtl/twiddle_ctrl.sv
// Rotary-encoder value editor: VIEW shows the committed value, a press enters EDIT, and a second press commits.
// Optional macro TWIDDLE_WRAP_EN: when defined, working wraps modulo 16; otherwise it saturates at 0 and 15.
module twiddle_ctrl #(
    parameter int BLINK_BITS   = 22,
    parameter int TIMEOUT_BITS = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       rot_a,
    input  logic       rot_b,
    output logic [3:0] disp,
    output logic [3:0] value,
    output logic       editing,
    output logic       commit
);
    typedef enum logic [1:0] {VIEW, EDIT, COMMIT} state_t;

    state_t                  state_reg;
    logic [1:0]              rot_raw;
    logic [1:0]              ab;
    logic [1:0]              prev_ab_reg;
    logic                    btn_reg;
    logic [BLINK_BITS-1:0]   blink_reg;
    logic [BLINK_BITS-1:0]   blink_next;
    logic [TIMEOUT_BITS-1:0] tmo_reg;
    logic [3:0]              value_reg;
    logic [3:0]              working_reg;
    logic [3:0]              working_adj;
    logic [3:0]              disp_reg;
    logic                    editing_reg;
    logic                    commit_reg;
    logic                    step_up;
    logic                    step_down;
    logic                    press;
    logic                    tmo_expired;
    logic                    blink_on;

    assign rot_raw = {rot_a, rot_b};

    // Two-flop synchronizer per encoder channel; the idle (pulled-up) level is 1.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_reg <= 1'b1;
                sync_reg <= 1'b1;
            end else begin
                meta_reg <= rot_raw[gi];
                sync_reg <= meta_reg;
            end
        end
        assign ab[gi] = sync_reg;
    end

    always_comb begin
        step_up     = (prev_ab_reg == 2'b10) && (ab == 2'b11);
        step_down   = (prev_ab_reg == 2'b01) && (ab == 2'b11);
        press       = btn_reg & ~btn_n;
        tmo_expired = &tmo_reg;
        blink_next  = blink_reg + 1'b1;
        blink_on    = blink_next[BLINK_BITS-1];
        working_adj = working_reg;
`ifdef TWIDDLE_WRAP_EN
        if (step_up) begin
            working_adj = working_reg + 4'd1;
        end else if (step_down) begin
            working_adj = working_reg - 4'd1;
        end
`else
        if (step_up && (working_reg != 4'hF)) begin
            working_adj = working_reg + 4'd1;
        end else if (step_down && (working_reg != 4'h0)) begin
            working_adj = working_reg - 4'd1;
        end
`endif
    end

    // Outputs are registered alongside the state they describe, so they
    // always reflect the state being entered on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= VIEW;
            prev_ab_reg <= 2'b11;
            btn_reg     <= 1'b1;
            blink_reg   <= '0;
            tmo_reg     <= '0;
            value_reg   <= 4'd0;
            working_reg <= 4'd0;
            disp_reg    <= 4'd0;
            editing_reg <= 1'b0;
            commit_reg  <= 1'b0;
        end else begin
            prev_ab_reg <= ab;
            btn_reg     <= btn_n;
            blink_reg   <= blink_next;
            commit_reg  <= 1'b0;
            case (state_reg)
                VIEW: begin
                    if (press) begin
                        state_reg   <= EDIT;
                        working_reg <= value_reg;
                        tmo_reg     <= '0;
                        editing_reg <= 1'b1;
                        disp_reg    <= blink_on ? value_reg : 4'd0;
                    end else begin
                        editing_reg <= 1'b0;
                        disp_reg    <= value_reg;
                    end
                end
                EDIT: begin
                    working_reg <= working_adj;
                    if (press) begin
                        // A step landing in the same cycle is already folded into working_adj.
                        state_reg   <= COMMIT;
                        value_reg   <= working_adj;
                        commit_reg  <= 1'b1;
                        editing_reg <= 1'b0;
                        disp_reg    <= working_adj;
                    end else if (step_up || step_down) begin
                        tmo_reg  <= '0;
                        disp_reg <= blink_on ? working_adj : 4'd0;
                    end else if (tmo_expired) begin
                        state_reg   <= VIEW;
                        editing_reg <= 1'b0;
                        disp_reg    <= value_reg;
                    end else begin
                        tmo_reg  <= tmo_reg + 1'b1;
                        disp_reg <= blink_on ? working_adj : 4'd0;
                    end
                end
                COMMIT: begin
                    state_reg   <= VIEW;
                    editing_reg <= 1'b0;
                    disp_reg    <= value_reg;
                end
                default: begin
                    state_reg   <= VIEW;
                    editing_reg <= 1'b0;
                    disp_reg    <= value_reg;
                end
            endcase
        end
    end

    assign disp    = disp_reg;
    assign value   = value_reg;
    assign editing = editing_reg;
    assign commit  = commit_reg;
endmodule
